// File: rtl/instr_sequencer.sv
// Multi-cycle FSM sequencer for the single-issue MIPS datapath: gates stage enables,
// stalls on multiply and data memory, counts retires. Optional macro: SEQ_TIMEOUT_EN.
module instr_sequencer #(
  parameter int MUL_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Run,
  input  logic [5:0]  OpCode,
  input  logic        MemAck,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        AluStart,
  output logic        RegWriteEn,
  output logic        MemReq,
  output logic        MemReadEn,
  output logic        MemWriteEn,
  output logic        IllegalOp,
  output logic        Busy,
  output logic        Fault,
  output logic [15:0] InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MULWAIT, S_MEMORY, S_WRITEBACK
  } state_e;

  typedef enum logic [2:0] {C_R, C_IMM, C_MUL, C_LD, C_ST, C_ILL} cls_e;

  localparam logic [5:0] OP_MUL = 6'b011100;

  if (MUL_CYCLES < 1 || MUL_CYCLES > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("instr_sequencer: MUL_CYCLES must be 1..15 and TIMEOUT_CYCLES >= 1");
  end

  function automatic cls_e classify(input logic [5:0] op);
    case (op)
      6'b000000, 6'b011111: classify = C_R;
      OP_MUL:               classify = C_MUL;
      6'b100011:            classify = C_LD;
      6'b101011:            classify = C_ST;
      default:              classify = (op[5:3] == 3'b001 && op[2:0] != 3'b111) ? C_IMM : C_ILL;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [3:0]  mul_cnt_q, mul_cnt_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic        pc_write_q, pc_write_d;
  logic        ir_write_q, ir_write_d;
  logic        alu_start_q, alu_start_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        busy_q, busy_d;
  logic        fault;
  logic        retire;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          fault_q, fault_d;
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    mul_cnt_d     = mul_cnt_q;
    instr_count_d = instr_count_q;
    retire        = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    fault_d   = fault_q;
    tmo_cnt_d = '0;
`endif
    case (state_q)
      S_IDLE:   if (Run && !fault) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d = OpCode;
        if (classify(OpCode) == C_ILL) state_d = Run ? S_FETCH : S_IDLE;
        else                           state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (classify(op_q))
          C_MUL: begin
            state_d   = S_MULWAIT;
            mul_cnt_d = 4'(MUL_CYCLES - 1);
          end
          C_LD, C_ST: state_d = S_MEMORY;
          default:    state_d = S_WRITEBACK;
        endcase
      end
      S_MULWAIT: begin
        if (mul_cnt_q == 4'd0) state_d = S_WRITEBACK;
        else                   mul_cnt_d = mul_cnt_q - 4'd1;
      end
      S_MEMORY: begin
        if (MemAck) begin
          if (classify(op_q) == C_ST) retire = 1'b1;
          else                        state_d = S_WRITEBACK;
        end
`ifdef SEQ_TIMEOUT_EN
        // Abandon the access: no writeback, no retire, sticky until reset.
        else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          fault_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      S_WRITEBACK: retire = 1'b1;
      default:     state_d = S_IDLE;
    endcase

    if (retire) begin
      instr_count_d = instr_count_q + 16'd1;
      state_d       = Run ? S_FETCH : S_IDLE;
    end

    // Outputs are registered from the next state so they line up with state_q.
    pc_write_d  = (state_d == S_FETCH);
    ir_write_d  = (state_d == S_FETCH);
    alu_start_d = (state_d == S_EXECUTE) && (op_d == OP_MUL);
    reg_write_d = (state_d == S_WRITEBACK);
    mem_req_d   = (state_d == S_MEMORY);
    mem_read_d  = mem_req_d && (classify(op_d) == C_LD);
    mem_write_d = mem_req_d && (classify(op_d) == C_ST);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      mul_cnt_q     <= '0;
      instr_count_q <= '0;
      pc_write_q    <= 1'b0;
      ir_write_q    <= 1'b0;
      alu_start_q   <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      busy_q        <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      mul_cnt_q     <= mul_cnt_d;
      instr_count_q <= instr_count_d;
      pc_write_q    <= pc_write_d;
      ir_write_q    <= ir_write_d;
      alu_start_q   <= alu_start_d;
      reg_write_q   <= reg_write_d;
      mem_req_q     <= mem_req_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      busy_q        <= busy_d;
`ifdef SEQ_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      fault_q       <= fault_d;
`endif
    end
  end

  // OpCode is only valid from DECODE, so the illegal pulse cannot be registered ahead.
  assign IllegalOp  = (state_q == S_DECODE) && (classify(OpCode) == C_ILL);
  assign PCWrite    = pc_write_q;
  assign IRWrite    = ir_write_q;
  assign AluStart   = alu_start_q;
  assign RegWriteEn = reg_write_q;
  assign MemReq     = mem_req_q;
  assign MemReadEn  = mem_read_q;
  assign MemWriteEn = mem_write_q;
  assign Busy       = busy_q;
  assign Fault      = fault;
  assign InstrCount = instr_count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a per-cycle vector queue built from the
// instruction-class timing rules drives the inputs and is checked every cycle.
module tb_instr_sequencer;

  localparam int MULC = 4;
  localparam int TMO  = 64;

  logic        Clk = 1'b0;
  logic        Rst, Run, MemAck;
  logic [5:0]  OpCode;
  logic        PCWrite, IRWrite, AluStart, RegWriteEn, MemReq, MemReadEn, MemWriteEn;
  logic        IllegalOp, Busy, Fault;
  logic [15:0] InstrCount;

  instr_sequencer #(.MUL_CYCLES(MULC), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk(Clk), .Rst(Rst), .Run(Run), .OpCode(OpCode), .MemAck(MemAck),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .AluStart(AluStart), .RegWriteEn(RegWriteEn),
    .MemReq(MemReq), .MemReadEn(MemReadEn), .MemWriteEn(MemWriteEn),
    .IllegalOp(IllegalOp), .Busy(Busy), .Fault(Fault), .InstrCount(InstrCount)
  );

  always #5 Clk = ~Clk;

  // o = {irw, pcw, alu, rwe, req, rd, wr, ill, busy, fault}
  typedef struct {
    logic        rst, run, ack, pre;
    logic [5:0]  op;
    logic [9:0]  o;
    logic [15:0] cnt;
  } vec_t;

  vec_t        q[$];
  logic [15:0] m_cnt   = 16'd0;
  logic        m_fault = 1'b0;
  int          n_chk   = 0;
  int          n_pass  = 0;

  function automatic vec_t mk(input logic run, input logic ack, input logic [5:0] op,
                              input logic [8:0] o9);
    vec_t v;
    v.rst = 1'b1; v.run = run; v.ack = ack; v.pre = 1'b0; v.op = op;
    v.o = {o9, m_fault}; v.cnt = m_cnt;
    return v;
  endfunction

  task automatic push_reset();
    vec_t v;
    m_cnt = 16'd0; m_fault = 1'b0;
    v = mk(1'b0, 1'b0, 6'd0, 9'b0);
    v.rst = 1'b0;
    q.push_back(v);
  endtask

  task automatic push_idle(input logic run, input logic pre);
    vec_t v;
    v = mk(run, 1'b0, 6'd0, 9'b0);
    v.pre = pre;
    q.push_back(v);
    if (pre) m_cnt = 16'hFFFF;
  endtask

  // w >= 0: MEMORY waits w cycles before MemAck; w < 0: MemAck never comes.
  // abort > 0 keeps only the first 'abort' cycles (a reset follows).
  task automatic push_instr(input logic [5:0] op, input int w, input logic run,
                            input logic noise, input int abort, output int len);
    vec_t s[$];
    bit is_r, is_imm, is_mul, is_ld, is_st, is_ill, retires;
    int nmem;
    is_r   = (op == 6'b000000 || op == 6'b011111);
    is_imm = (op >= 6'b001000 && op <= 6'b001110);
    is_mul = (op == 6'b011100);
    is_ld  = (op == 6'b100011);
    is_st  = (op == 6'b101011);
    is_ill = !(is_r || is_imm || is_mul || is_ld || is_st);
    retires = !is_ill && (w >= 0);
    s.push_back(mk(run, noise, op, 9'b110000001));
    if (is_ill) s.push_back(mk(run, noise, op, 9'b000000011));
    else begin
      s.push_back(mk(run, noise, op, 9'b000000001));
      s.push_back(mk(run, noise, op, is_mul ? 9'b001000001 : 9'b000000001));
      if (is_mul) for (int i = 0; i < MULC; i++) s.push_back(mk(run, noise, op, 9'b000000001));
      if (is_ld || is_st) begin
        nmem = (w < 0) ? TMO : w + 1;
        for (int i = 0; i < nmem; i++)
          s.push_back(mk(run, (w >= 0 && i == w), op, is_ld ? 9'b000011001 : 9'b000010101));
        if (w < 0) m_fault = 1'b1;
      end
      if (retires && !is_st) s.push_back(mk(run, noise, op, 9'b000100001));
    end
    len = s.size();
    if (abort > 0) while (s.size() > abort) void'(s.pop_back());
    foreach (s[i]) q.push_back(s[i]);
    if (retires && abort == 0) m_cnt = m_cnt + 16'd1;
  endtask

  task automatic pin_len(input string name, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL len_%s: model cycles %0d, expected %0d", name, got, want);
  endtask

  initial begin
    int len;
    vec_t v;
    logic [9:0] dut_o;
    Rst = 1'b1; Run = 1'b0; MemAck = 1'b0; OpCode = 6'd0;
    #2 Rst = 1'b0;

    push_reset(); push_reset();
    push_idle(1'b0, 1'b0); push_idle(1'b1, 1'b0);
    push_instr(6'b000000, 0, 1'b1, 1'b0, 0, len); pin_len("r",    len, 4);
    push_instr(6'b011100, 0, 1'b1, 1'b0, 0, len); pin_len("mul",  len, 8);
    push_instr(6'b100011, 2, 1'b1, 1'b1, 0, len); pin_len("ld_w2", len, 7);
    push_instr(6'b101011, 0, 1'b1, 1'b0, 0, len); pin_len("st_w0", len, 4);
    push_instr(6'b111111, 0, 1'b1, 1'b0, 0, len); pin_len("ill",  len, 2);
    push_instr(6'b001010, 0, 1'b1, 1'b0, 0, len); pin_len("slti", len, 4);
    push_instr(6'b011111, 0, 1'b1, 1'b0, 0, len);
    push_instr(6'b001110, 0, 1'b1, 1'b0, 0, len);
    push_instr(6'b001111, 0, 1'b1, 1'b0, 0, len); pin_len("ill_001111", len, 2);
    push_instr(6'b101011, 3, 1'b0, 1'b0, 0, len); pin_len("st_w3", len, 7);
    push_idle(1'b0, 1'b0);
    // Preload the counter to FFFF instead of clocking 65535 retires.
    push_idle(1'b0, 1'b1);
    push_idle(1'b1, 1'b0);
    push_instr(6'b001000, 0, 1'b0, 1'b0, 0, len);
    push_idle(1'b0, 1'b0); push_idle(1'b0, 1'b0);
    push_idle(1'b1, 1'b0);
    push_instr(6'b011100, 0, 1'b1, 1'b0, 5, len);
    push_reset();
    push_idle(1'b0, 1'b0); push_idle(1'b1, 1'b0);
    push_instr(6'b000000, 0, 1'b0, 1'b0, 0, len);
    push_idle(1'b0, 1'b0);
`ifdef SEQ_TIMEOUT_EN
    push_idle(1'b1, 1'b0);
    push_instr(6'b100011, -1, 1'b1, 1'b0, 0, len); pin_len("ld_tmo", len, 3 + TMO);
    for (int i = 0; i < 4; i++) push_idle(1'b1, 1'b0);
    push_reset();
    push_idle(1'b1, 1'b0);
    push_instr(6'b000000, 0, 1'b0, 1'b0, 0, len);
    push_idle(1'b0, 1'b0);
`endif

    for (int k = 0; q.size() > 0; k++) begin
      v = q.pop_front();
      @(posedge Clk); #1;
      Rst = v.rst; Run = v.run; MemAck = v.ack; OpCode = v.op;
      @(negedge Clk);
      dut_o = {IRWrite, PCWrite, AluStart, RegWriteEn, MemReq, MemReadEn, MemWriteEn,
               IllegalOp, Busy, Fault};
      n_chk++;
      if (dut_o === v.o) n_pass++;
      else $display("FAIL outputs step %0d: got %b want %b (irw pcw alu rwe req rd wr ill busy fault)",
                    k, dut_o, v.o);
      n_chk++;
      if (InstrCount === v.cnt) n_pass++;
      else $display("FAIL instr_count step %0d: got %h want %h", k, InstrCount, v.cnt);
      if (v.pre) begin
        force dut.instr_count_q = 16'hFFFF;
        #1 release dut.instr_count_q;
      end
    end

    @(negedge Clk);
    n_chk++;
    if (InstrCount === 16'd1 && Busy === 1'b0) n_pass++;
    else $display("FAIL final_state: count %h busy %b, want 0001 and 0", InstrCount, Busy);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
